sobel_frame_sequencer: RTL

Frame-level scheduler between spi_control and the Sobel window/line-buffer datapath. It counts incoming grayscale pixels over an IMG_WIDTH x IMG_HEIGHT frame and drives line-buffer shifts. It issues window-valid strobes only for fully interior 3x3 windows, and returns exactly one result pixel per input pixel after fixed latency: the Sobel result for valid windows, 0 for border windows. It also sequences frame start, fill, run, drain and done.

---
 rtl/sobel_frame_sequencer_pkg.sv | 18 +
 rtl/sobel_frame_sequencer_seq_tag_pipe.sv | 38 +++
 rtl/sobel_frame_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sobel_frame_sequencer_pkg.sv
// Shared types and defaults for the Sobel frame sequencer.
// Result pixels carry the Sobel magnitude, so they are wider than the 8-bit gray input.
package sobel_frame_sequencer_pkg;

    localparam int MAX_PIXEL_BITS    = 16;
    localparam int IMG_WIDTH_DEF     = 64;
    localparam int IMG_HEIGHT_DEF    = 64;
    localparam int SOBEL_LATENCY_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/sobel_frame_sequencer_seq_tag_pipe.sv
// Delay line for the {shift, valid} tag of each accepted pixel.
// It runs alongside the Sobel datapath so that each result can be matched to the pixel that produced it.
module seq_tag_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic nreset_i,
    input  logic flush_i,
    input  logic shift_i,
    input  logic valid_i,
    output logic shift_o,
    output logic valid_o
);

    logic [DEPTH-1:0] shift_q;
    logic [DEPTH-1:0] valid_q;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            shift_q <= '0;
            valid_q <= '0;
        end else if (flush_i) begin
            shift_q <= '0;
            valid_q <= '0;
        end else begin
            shift_q[0] <= shift_i;
            valid_q[0] <= valid_i;
            for (int i = 1; i < DEPTH; i++) begin
                shift_q[i] <= shift_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign shift_o = shift_q[DEPTH-1];
    assign valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/sobel_frame_sequencer.sv
// Frame scheduler between spi_control and the Sobel line-buffer/window datapath.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | waiting for frame_start_i
//   ST_FILL  | accepting rows 0..1; no interior window is possible yet
//   ST_RUN   | accepting rows 2..H-1; interior windows are strobed
//   ST_DRAIN | waiting SOBEL_LATENCY+2 cycles for the last results to leave
//   ST_DONE  | frame_done_o for one cycle
module sobel_frame_sequencer
    import sobel_frame_sequencer_pkg::*;
#(
    parameter int IMG_WIDTH     = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT    = IMG_HEIGHT_DEF,
    parameter int SOBEL_LATENCY = SOBEL_LATENCY_DEF
) (
    input  logic                          clk_i,
    input  logic                          nreset_i,
    input  logic                          frame_start_i,
    input  logic [MAX_PIXEL_BITS-1:0]     px_in_i,
    input  logic                          px_in_rdy_i,
    output logic                          win_shift_o,
    output logic [MAX_PIXEL_BITS-1:0]     win_px_o,
    output logic                          win_valid_o,
    input  logic [MAX_PIXEL_BITS-1:0]     sobel_px_i,
    output logic [MAX_PIXEL_BITS-1:0]     px_out_o,
    output logic                          px_out_rdy_o,
    output logic [$clog2(IMG_WIDTH)-1:0]  col_o,
    output logic [$clog2(IMG_HEIGHT)-1:0] row_o,
    output logic [2:0]                    state_o,
    output logic                          frame_done_o,
    output logic                          overrun_o
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int DW = $clog2(SOBEL_LATENCY + 2);

    seq_state_e state_q, state_d;

    logic [CW-1:0]             col_q;
    logic [RW-1:0]             row_q;
    logic [DW-1:0]             drain_q;
    logic                      win_shift_q;
    logic                      win_valid_q;
    logic [MAX_PIXEL_BITS-1:0] win_px_q;
    logic [MAX_PIXEL_BITS-1:0] px_out_q;
    logic                      px_out_rdy_q;
    logic                      overrun_q;
    logic                      tag_shift;
    logic                      tag_valid;

    logic accept;
    logic last_col;
    logic fill_end;
    logic frame_end;

    assign accept    = px_in_rdy_i && !frame_start_i &&
                       (state_q == ST_FILL || state_q == ST_RUN);
    assign last_col  = (col_q == CW'(IMG_WIDTH - 1));
    assign fill_end  = accept && last_col && (row_q == RW'(1));
    assign frame_end = accept && last_col && (row_q == RW'(IMG_HEIGHT - 1));

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_IDLE;
            ST_FILL:  if (fill_end) state_d = ST_RUN;
            ST_RUN:   if (frame_end) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_q == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // A start pulse aborts whatever is in progress, including a pending done.
        if (frame_start_i) state_d = ST_FILL;
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            drain_q <= '0;
        end else if (frame_start_i) begin
            drain_q <= '0;
        end else if (state_q == ST_RUN && frame_end) begin
            drain_q <= DW'(SOBEL_LATENCY + 1);
        end else if (state_q == ST_DRAIN && drain_q != '0) begin
            drain_q <= drain_q - DW'(1);
        end
    end

    // The row counter stays at the last row; the FSM leaves RUN on that pixel.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (frame_start_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (last_col) begin
                col_q <= '0;
                if (row_q != RW'(IMG_HEIGHT - 1)) row_q <= row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            win_shift_q <= 1'b0;
            win_valid_q <= 1'b0;
            win_px_q    <= '0;
        end else begin
            win_shift_q <= accept;
            win_valid_q <= accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
            if (accept) win_px_q <= px_in_i;
        end
    end

    seq_tag_pipe #(
        .DEPTH (SOBEL_LATENCY)
    ) u_tag_pipe (
        .clk_i    (clk_i),
        .nreset_i (nreset_i),
        .flush_i  (frame_start_i),
        .shift_i  (win_shift_q),
        .valid_i  (win_valid_q),
        .shift_o  (tag_shift),
        .valid_o  (tag_valid)
    );

    // Border pixels still produce a result (zero) so the output stream stays one-for-one.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            px_out_q     <= '0;
            px_out_rdy_q <= 1'b0;
        end else if (frame_start_i) begin
            px_out_rdy_q <= 1'b0;
        end else begin
            px_out_rdy_q <= tag_shift;
            if (tag_shift) px_out_q <= tag_valid ? sobel_px_i : '0;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            overrun_q <= 1'b0;
        end else if (frame_start_i) begin
            overrun_q <= 1'b0;
        end else if (px_in_rdy_i && !accept) begin
            overrun_q <= 1'b1;
        end
    end

    assign win_shift_o  = win_shift_q;
    assign win_valid_o  = win_valid_q;
    assign win_px_o     = win_px_q;
    assign px_out_o     = px_out_q;
    assign px_out_rdy_o = px_out_rdy_q;
    assign col_o        = col_q;
    assign row_o        = row_q;
    assign state_o      = state_q;
    assign frame_done_o = (state_q == ST_DONE);
    assign overrun_o    = overrun_q;

endmodule
